// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-FU result FIFOs, round-robin pick onto a registered CDB,
// with mispredict squash of buffered results younger than the branch.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int PREG_W     = 7,
  parameter int ROB_TAG_W  = 4,
  parameter int DATA_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid_in,
  output logic                 alu_ready_out,
  input  logic [PREG_W-1:0]    alu_prd_in,
  input  logic [DATA_W-1:0]    alu_data_in,
  input  logic [ROB_TAG_W-1:0] alu_rob_tag_in,
  input  logic                 alu_has_rd_in,
  input  logic                 b_valid_in,
  output logic                 b_ready_out,
  input  logic [PREG_W-1:0]    b_prd_in,
  input  logic [DATA_W-1:0]    b_data_in,
  input  logic [ROB_TAG_W-1:0] b_rob_tag_in,
  input  logic                 b_has_rd_in,
  input  logic                 lsu_valid_in,
  output logic                 lsu_ready_out,
  input  logic [PREG_W-1:0]    lsu_prd_in,
  input  logic [DATA_W-1:0]    lsu_data_in,
  input  logic [ROB_TAG_W-1:0] lsu_rob_tag_in,
  input  logic                 lsu_has_rd_in,
  input  logic [ROB_TAG_W-1:0] rob_head_tag,
  input  logic                 mispredict,
  input  logic [ROB_TAG_W-1:0] mispredict_tag,
  output logic                 cdb_valid,
  output logic [PREG_W-1:0]    cdb_prd,
  output logic [DATA_W-1:0]    cdb_data,
  output logic [ROB_TAG_W-1:0] cdb_rob_tag,
  output logic                 prf_we
);

  localparam int NFU   = 3;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {FU_ALU = 2'd0, FU_BR = 2'd1, FU_LSU = 2'd2} fu_e;

  typedef struct packed {
    logic [PREG_W-1:0]    prd;
    logic [DATA_W-1:0]    data;
    logic [ROB_TAG_W-1:0] tag;
    logic                 has_rd;
  } entry_t;

  function automatic fu_e next_fu(input fu_e f);
    case (f)
      FU_ALU:  return FU_BR;
      FU_BR:   return FU_LSU;
      default: return FU_ALU;
    endcase
  endfunction

  // Distances from the ROB head make the compare immune to tag wraparound.
  function automatic logic is_younger(input logic [ROB_TAG_W-1:0] t,
                                      input logic [ROB_TAG_W-1:0] head,
                                      input logic [ROB_TAG_W-1:0] br);
    logic [ROB_TAG_W-1:0] d_t;
    logic [ROB_TAG_W-1:0] d_br;
    d_t  = t - head;
    d_br = br - head;
    return d_t > d_br;
  endfunction

  entry_t           mem_q [NFU][FIFO_DEPTH];
  entry_t           mem_d [NFU][FIFO_DEPTH];
  logic [CNT_W-1:0] cnt_q [NFU];
  logic [CNT_W-1:0] cnt_d [NFU];
  fu_e              rr_q, rr_d;

  entry_t           in_ent [NFU];
  logic [NFU-1:0]   in_valid, ready, push, pop;
  logic             grant_any;
  fu_e              grant_fu;
  entry_t           g_ent;
  logic             cdb_valid_d;

  logic                 cdb_valid_q, prf_we_q;
  logic [PREG_W-1:0]    cdb_prd_q;
  logic [DATA_W-1:0]    cdb_data_q;
  logic [ROB_TAG_W-1:0] cdb_tag_q;

  assign in_ent[FU_ALU] = '{prd: alu_prd_in, data: alu_data_in, tag: alu_rob_tag_in, has_rd: alu_has_rd_in};
  assign in_ent[FU_BR]  = '{prd: b_prd_in,   data: b_data_in,   tag: b_rob_tag_in,   has_rd: b_has_rd_in};
  assign in_ent[FU_LSU] = '{prd: lsu_prd_in, data: lsu_data_in, tag: lsu_rob_tag_in, has_rd: lsu_has_rd_in};
  assign in_valid = {lsu_valid_in, b_valid_in, alu_valid_in};

  always_comb begin
    for (int f = 0; f < NFU; f++) begin
      ready[f] = cnt_q[f] < DEPTH_C;
    end
  end

  assign push          = in_valid & ready;
  assign alu_ready_out = ready[FU_ALU];
  assign b_ready_out   = ready[FU_BR];
  assign lsu_ready_out = ready[FU_LSU];

  always_comb begin
    fu_e cand;
    // NOTE: every variable written here is given a default first, so no latch is inferred.
    grant_any = 1'b0;
    grant_fu  = rr_q;
    cand      = rr_q;
    pop       = '0;
    for (int k = 0; k < NFU; k++) begin
      if (!grant_any && cnt_q[cand] != '0) begin
        grant_any = 1'b1;
        grant_fu  = cand;
      end
      cand = next_fu(cand);
    end
    pop[grant_fu] = grant_any;
    rr_d          = grant_any ? next_fu(grant_fu) : rr_q;
    g_ent         = mem_q[grant_fu][0];
    cdb_valid_d   = grant_any &&
                    !(mispredict && is_younger(g_ent.tag, rob_head_tag, mispredict_tag));
  end

  // Head lives at index 0; survivors are packed down in order, then the push is appended.
  always_comb begin
    logic [CNT_W-1:0] n;
    mem_d = mem_q;
    n     = '0;
    for (int f = 0; f < NFU; f++) begin
      n = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (CNT_W'(i) < cnt_q[f] && !(i == 0 && pop[f]) &&
            !(mispredict && is_younger(mem_q[f][i].tag, rob_head_tag, mispredict_tag))) begin
          if (n < DEPTH_C) mem_d[f][n[IDX_W-1:0]] = mem_q[f][i];
          n = n + 1'b1;
        end
      end
      if (push[f] && !(mispredict && is_younger(in_ent[f].tag, rob_head_tag, mispredict_tag))) begin
        if (n < DEPTH_C) mem_d[f][n[IDX_W-1:0]] = in_ent[f];
        n = n + 1'b1;
      end
      cnt_d[f] = n;
    end
  end

  // NOTE: payload storage is not reset; the per-FIFO count alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '{default: '0};
      rr_q        <= FU_ALU;
      cdb_valid_q <= 1'b0;
      prf_we_q    <= 1'b0;
      cdb_prd_q   <= '0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      prf_we_q    <= cdb_valid_d & g_ent.has_rd;
      if (cdb_valid_d) begin
        cdb_prd_q  <= g_ent.prd;
        cdb_data_q <= g_ent.data;
        cdb_tag_q  <= g_ent.tag;
      end
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign prf_we      = prf_we_q;
  assign cdb_prd     = cdb_prd_q;
  assign cdb_data    = cdb_data_q;
  assign cdb_rob_tag = cdb_tag_q;

endmodule
